ex_stage_pipe: RTL
==================

Name: ex_stage_pipe

Overview:
- Parametrised, registered successor to the combinational execute stage: ALU, branch/jump resolution and next-PC generation, behind a valid/ready handshake.
- Sits between ID/EX and MEM. Holds one output register. Issues a registered redirect to fetch for taken branches and jumps.
- Supports a synchronous flush. An iterative multiplier can optionally be compiled in.

Parameters:
XLEN, 32, datapath width (PC, operands, result)
REG_AW, 5, destination register address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of held and in-flight work
in_valid  in  1  ID/EX presents an instruction
in_ready  out  1  stage can accept this cycle
alu_ctl  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11-15 reserved
alu_src  in  1  1: operand B = imm; 0: operand B = rs2
br_type  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL
jalr  in  1  JALR instruction; overrides br_type
pc  in  XLEN  instruction PC
imm  in  XLEN  sign-extended immediate
rs1  in  XLEN  source operand 1
rs2  in  XLEN  source operand 2
rd_addr  in  REG_AW  destination register
out_valid  out  1  EX/MEM result held
out_ready  in  1  MEM accepts the held result
out_result  out  XLEN  ALU result, or pc+4 for JAL/JALR
out_rs2  out  XLEN  store data (registered rs2)
out_rd_addr  out  REG_AW  registered rd_addr
redirect_valid  out  1  one-cycle pulse: fetch must jump
redirect_pc  out  XLEN  jump target

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept: an instruction is accepted when in_valid && in_ready. Non-MUL ops load the output register at that edge (latency 1).
- out_valid set on load. Cleared when out_ready && !load, or on flush. A load in the same cycle as out_ready is a back-to-back replace, with no bubble.
- Arithmetic:
  - All arithmetic is modulo 2^XLEN.
  - Shift amount = operand B[$clog2(XLEN)-1:0].
  - SLT/SLTU produce 1 or 0, zero-extended.
  - Reserved codes produce result 0.
- Branch compare:
  - Computed directly on rs1 vs rs2, not from the ALU sign bit. Overflow-safe signed compare.
  - BLT/BGE are signed; BLTU/BGEU are unsigned.
- Redirect:
  - Taken branch or JAL: redirect_pc = pc+imm.
  - JALR: redirect_pc = (rs1+imm) with bit 0 cleared.
  - Not-taken branch and br_type 0: no redirect (fetch predicts not-taken).
  - redirect_valid is registered. It pulses exactly one cycle, coincident with the cycle out_valid first rises for that instruction.
- Link: JAL and JALR set out_result = pc+4, regardless of alu_ctl.
- FSM (only with the optional feature): IDLE -> MUL on accept of alu_ctl==10.
  - MUL runs XLEN iterations of shift-add on the counter.
  - Counter == XLEN-1 -> WB. WB loads the output register once it is free, then returns to IDLE.
  - MUL latency = XLEN+1 cycles from accept to out_valid.
  - in_ready = 0 throughout MUL and WB.
- Flush:
  - Clears out_valid and suppresses any pending redirect_valid.
  - Aborts MUL/WB to IDLE and clears the counter.
  - An in_valid in the flush cycle is not accepted.
  - Flush has priority over every other event.
- Reset mid-MUL: returns to IDLE, discards the partial product.
- Stall: while out_valid && !out_ready, all out_* fields hold stable.

Optional Feature:
EX_MUL_EN
- Defined: MUL (alu_ctl 10) is implemented as above. The result is the low XLEN bits of rs1*operand B.
- Undefined: the FSM, counter and multiplier datapath are omitted. alu_ctl 10 is treated as reserved (result 0, latency 1), and in_ready depends only on the output register.

Test Plan:
- Reset: rst_n low mid-stream -> all outputs 0 immediately. First accept after release has latency 1.
- ALU: ADD 0x7FFFFFFF+1 -> 0x80000000; SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; code 13 -> 0.
- Branch: BLT rs1=0x80000000, rs2=0x7FFFFFFF, pc=0x100, imm=0x20 -> redirect_pc 0x120, one-cycle pulse. BGEU same operands -> taken. BEQ unequal -> no redirect.
- JALR: rs1=0x1003, imm=4, pc=0x40 -> redirect_pc 0x1006, out_result 0x44.
- Backpressure: hold out_ready low 3 cycles with in_valid high -> in_ready 0 and outputs stable. Release -> back-to-back accept with no bubble.
- EX_MUL_EN defined: MUL 0xFFFFFFFF*3 -> 0xFFFFFFFD after 33 cycles. Flush at cycle 10 -> no output and in_ready high the next cycle. Undefined: MUL -> 0 after 1 cycle.

Source files
------------

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: ALU, branch/jump resolution and fetch redirect behind valid/ready.
// Define EX_MUL_EN to build the iterative shift-add multiplier for alu_ctl 10.
module ex_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctl,
    input  logic              alu_src,
    input  logic [2:0]        br_type,
    input  logic              jalr,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [REG_AW-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_rs2,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0]   opB, aluRes, jalrSum, result_d, redirectPc_d;
    logic [SW-1:0]     shamt;
    logic              brTaken, taken_d, isLink, outFree, accept, loadAlu;
    logic              outValid_q, redirectValid_q;
    logic [XLEN-1:0]   outResult_q, outRs2_q, redirectPc_q;
    logic [REG_AW-1:0] outRd_q;

    // Branch compares use rs1/rs2 directly so signed ordering never depends on ALU overflow.
    always_comb begin
        opB    = alu_src ? imm : rs2;
        shamt  = opB[SW-1:0];
        aluRes = '0;
        case (alu_ctl)
            4'd0:    aluRes = rs1 + opB;
            4'd1:    aluRes = rs1 - opB;
            4'd2:    aluRes = rs1 << shamt;
            4'd3:    aluRes = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(opB))};
            4'd4:    aluRes = {{(XLEN-1){1'b0}}, (rs1 < opB)};
            4'd5:    aluRes = rs1 ^ opB;
            4'd6:    aluRes = rs1 >> shamt;
            4'd7:    aluRes = $signed(rs1) >>> shamt;
            4'd8:    aluRes = rs1 | opB;
            4'd9:    aluRes = rs1 & opB;
            default: aluRes = '0;
        endcase
        brTaken = 1'b0;
        case (br_type)
            3'd1:    brTaken = (rs1 == rs2);
            3'd2:    brTaken = (rs1 != rs2);
            3'd3:    brTaken = ($signed(rs1) < $signed(rs2));
            3'd4:    brTaken = ($signed(rs1) >= $signed(rs2));
            3'd5:    brTaken = (rs1 < rs2);
            3'd6:    brTaken = (rs1 >= rs2);
            3'd7:    brTaken = 1'b1;
            default: brTaken = 1'b0;
        endcase
        isLink       = jalr || (br_type == 3'd7);
        taken_d      = jalr || brTaken;
        jalrSum      = rs1 + imm;
        redirectPc_d = jalr ? (jalrSum & {{(XLEN-1){1'b1}}, 1'b0}) : (pc + imm);
        result_d     = isLink ? (pc + XLEN'(4)) : aluRes;
    end

    assign outFree = !outValid_q || out_ready;

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

    state_t            state_q;
    logic [SW-1:0]     cnt_q;
    logic [XLEN-1:0]   mcand_q, mplier_q, acc_q, mulRs2_q;
    logic [REG_AW-1:0] mulRd_q;
    logic              isMulOp, startMul, loadMul;

    assign isMulOp  = (alu_ctl == 4'd10) && (br_type == 3'd0) && !jalr;
    assign in_ready = (state_q == IDLE) && outFree && !flush;
    assign accept   = in_valid && in_ready;
    assign startMul = accept && isMulOp;
    assign loadAlu  = accept && !isMulOp;
    assign loadMul  = (state_q == WB) && outFree && !flush;

    // Iteration 0 happens on the accept edge, so the counter enters MUL at 1 and the
    // result lands XLEN+1 edges after accept, matching the latency-1 path's timing reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mulRs2_q <= '0;
            mulRd_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (startMul) begin
                    acc_q    <= opB[0] ? rs1 : '0;
                    mcand_q  <= rs1 << 1;
                    mplier_q <= opB >> 1;
                    mulRs2_q <= rs2;
                    mulRd_q  <= rd_addr;
                    cnt_q    <= SW'(1);
                    state_q  <= MUL;
                end
                MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SW'(1);
                    if (cnt_q == SW'(XLEN-1)) state_q <= WB;
                end
                WB: if (outFree) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign in_ready = outFree && !flush;
    assign accept   = in_valid && in_ready;
    assign loadAlu  = accept;
`endif

    // A load while MEM takes the old result replaces it in place, so there is no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q      <= 1'b0;
            outResult_q     <= '0;
            outRs2_q        <= '0;
            outRd_q         <= '0;
            redirectValid_q <= 1'b0;
            redirectPc_q    <= '0;
        end else if (flush) begin
            outValid_q      <= 1'b0;
            redirectValid_q <= 1'b0;
        end else begin
            redirectValid_q <= 1'b0;
            if (loadAlu) begin
                outValid_q      <= 1'b1;
                outResult_q     <= result_d;
                outRs2_q        <= rs2;
                outRd_q         <= rd_addr;
                redirectValid_q <= taken_d;
                if (taken_d) redirectPc_q <= redirectPc_d;
            end
`ifdef EX_MUL_EN
            else if (loadMul) begin
                outValid_q  <= 1'b1;
                outResult_q <= acc_q;
                outRs2_q    <= mulRs2_q;
                outRd_q     <= mulRd_q;
            end
`endif
            else if (out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = outValid_q;
    assign out_result     = outResult_q;
    assign out_rs2        = outRs2_q;
    assign out_rd_addr    = outRd_q;
    assign redirect_valid = redirectValid_q;
    assign redirect_pc    = redirectPc_q;

endmodule
